// File: rtl/usb_token_decoder.sv
// USB token decoder: parses PID/address/endpoint bytes from the SIE receive stream,
// holds IN/OUT/SETUP tokens for the protocol engine and reports SOF frame numbers.
module usb_token_decoder #(
    parameter int unsigned TOKEN_HOLD_TIMEOUT = 255
) (
    input  logic        clk48,
    input  logic        rst_n,
    input  logic        decodeEn,
    input  logic        busReset,
    input  logic [6:0]  deviceAddr,
    input  logic [7:0]  rxData,
    input  logic        rxDataValid,
    input  logic        rxIsLastByte,
    input  logic        keepPacket,
    output logic        rxAcceptNewData,
    output logic        tokenValid,
    output logic [3:0]  tokenPid,
    output logic [3:0]  tokenEp,
    input  logic        tokenReady,
    output logic        sofValid,
    output logic [10:0] frameNumber,
    output logic        pktError
);

    localparam int unsigned HoldCountWidth = 8;
    localparam logic [HoldCountWidth-1:0] HoldLimit = HoldCountWidth'(TOKEN_HOLD_TIMEOUT - 1);

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidSof   = 4'b0101;

    typedef enum logic [2:0] {
        sIdle,
        sPid,
        sAddr,
        sEndp,
        sDrain,
        sHold
    } stateType;

    stateType state, stateNext;

    logic [3:0]                pidReg, pidNext;
    logic [7:0]                byte1Reg, byte1Next;
    logic [HoldCountWidth-1:0] holdCount, holdCountNext;
    logic                      tokenValidNext;
    logic [3:0]                tokenPidNext, tokenEpNext;
    logic [10:0]               frameNext;
    logic                      sofNext, errNext, acceptNext;

    logic xfer, pidCheckOk, isTokenPid, lastXfer;

    assign xfer       = rxAcceptNewData && rxDataValid;
    assign lastXfer   = xfer && rxIsLastByte;
    assign pidCheckOk = (rxData[7:4] == ~rxData[3:0]);
    assign isTokenPid = (rxData[3:0] == PidOut) || (rxData[3:0] == PidIn) ||
                        (rxData[3:0] == PidSetup) || (rxData[3:0] == PidSof);

    // Next-state and next-output logic
    always_comb begin
        stateNext      = state;
        pidNext        = pidReg;
        byte1Next      = byte1Reg;
        holdCountNext  = holdCount;
        tokenValidNext = tokenValid;
        tokenPidNext   = tokenPid;
        tokenEpNext    = tokenEp;
        frameNext      = frameNumber;
        sofNext        = 1'b0;
        errNext        = 1'b0;

        case (state)
            sIdle: begin
                if (decodeEn) stateNext = sPid;
            end
            sPid: begin
                if (xfer) begin
                    if (!pidCheckOk) begin
                        errNext   = 1'b1;
                        stateNext = rxIsLastByte ? sIdle : sDrain;
                    end else if (isTokenPid) begin
                        pidNext = rxData[3:0];
                        // A token PID with no address/endpoint bytes is a length failure
                        if (rxIsLastByte) begin
                            errNext   = 1'b1;
                            stateNext = sIdle;
                        end else begin
                            stateNext = decodeEn ? sAddr : sDrain;
                        end
                    end else begin
                        stateNext = rxIsLastByte ? sIdle : sDrain;
                    end
                end else if (!decodeEn) begin
                    stateNext = sDrain;
                end
            end
            sAddr: begin
                if (xfer) begin
                    byte1Next = rxData;
                    if (rxIsLastByte) begin
                        errNext   = 1'b1;
                        stateNext = sIdle;
                    end else begin
                        stateNext = decodeEn ? sEndp : sDrain;
                    end
                end else if (!decodeEn) begin
                    stateNext = sDrain;
                end
            end
            sEndp: begin
                if (xfer) begin
                    if (!rxIsLastByte) begin
                        errNext   = 1'b1;
                        stateNext = sDrain;
                    end else if (!keepPacket) begin
                        errNext   = 1'b1;
                        stateNext = sIdle;
                    end else if (pidReg == PidSof) begin
                        frameNext = {rxData[2:0], byte1Reg};
                        sofNext   = 1'b1;
                        stateNext = sIdle;
                    end else if (byte1Reg[6:0] == deviceAddr) begin
                        tokenPidNext   = pidReg;
                        tokenEpNext    = {rxData[2:0], byte1Reg[7]};
                        tokenValidNext = 1'b1;
                        holdCountNext  = '0;
                        stateNext      = sHold;
                    end else begin
                        stateNext = sIdle;
                    end
                end else if (!decodeEn) begin
                    stateNext = sDrain;
                end
            end
            sDrain: begin
                if (lastXfer) stateNext = sIdle;
            end
            sHold: begin
                holdCountNext = holdCount + HoldCountWidth'(1);
                if (tokenReady) begin
                    tokenValidNext = 1'b0;
                    stateNext      = sIdle;
                end else if ((TOKEN_HOLD_TIMEOUT != 0) && (holdCount == HoldLimit)) begin
                    tokenValidNext = 1'b0;
                    stateNext      = sIdle;
                end
            end
            default: stateNext = sIdle;
        endcase

        // Bus reset aborts whatever was in flight, including a completing packet
        if (busReset) begin
            stateNext      = sIdle;
            pidNext        = pidReg;
            byte1Next      = byte1Reg;
            holdCountNext  = '0;
            tokenValidNext = 1'b0;
            tokenPidNext   = tokenPid;
            tokenEpNext    = tokenEp;
            frameNext      = frameNumber;
            sofNext        = 1'b0;
            errNext        = 1'b0;
        end

        acceptNext = (stateNext == sPid) || (stateNext == sAddr) ||
                     (stateNext == sEndp) || (stateNext == sDrain);
    end

    // State and output registers
    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            state           <= sIdle;
            pidReg          <= '0;
            byte1Reg        <= '0;
            holdCount       <= '0;
            rxAcceptNewData <= 1'b0;
            tokenValid      <= 1'b0;
            tokenPid        <= '0;
            tokenEp         <= '0;
            frameNumber     <= '0;
            sofValid        <= 1'b0;
            pktError        <= 1'b0;
        end else begin
            state           <= stateNext;
            pidReg          <= pidNext;
            byte1Reg        <= byte1Next;
            holdCount       <= holdCountNext;
            rxAcceptNewData <= acceptNext;
            tokenValid      <= tokenValidNext;
            tokenPid        <= tokenPidNext;
            tokenEp         <= tokenEpNext;
            frameNumber     <= frameNext;
            sofValid        <= sofNext;
            pktError        <= errNext;
        end
    end

endmodule

// File: tb/tb_usb_token_decoder.sv
// Directed bench for usb_token_decoder: expected token/SOF/error events are queued as
// packets are sent and matched by a monitor when the decoder reports them.
module tb_usb_token_decoder;

    logic        clk48;
    logic        rst_n;
    logic        decodeEn;
    logic        busReset;
    logic [6:0]  deviceAddr;
    logic [7:0]  rxData;
    logic        rxDataValid;
    logic        rxIsLastByte;
    logic        keepPacket;
    logic        rxAcceptNewData;
    logic        tokenValid;
    logic [3:0]  tokenPid;
    logic [3:0]  tokenEp;
    logic        tokenReady;
    logic        sofValid;
    logic [10:0] frameNumber;
    logic        pktError;

    usb_token_decoder #(.TOKEN_HOLD_TIMEOUT(255)) dut (
        .clk48          (clk48),
        .rst_n          (rst_n),
        .decodeEn       (decodeEn),
        .busReset       (busReset),
        .deviceAddr     (deviceAddr),
        .rxData         (rxData),
        .rxDataValid    (rxDataValid),
        .rxIsLastByte   (rxIsLastByte),
        .keepPacket     (keepPacket),
        .rxAcceptNewData(rxAcceptNewData),
        .tokenValid     (tokenValid),
        .tokenPid       (tokenPid),
        .tokenEp        (tokenEp),
        .tokenReady     (tokenReady),
        .sofValid       (sofValid),
        .frameNumber    (frameNumber),
        .pktError       (pktError)
    );

    typedef struct packed {
        logic [1:0]  kind;  // 1 token, 2 sof, 3 error
        logic [10:0] val;
    } evType;

    evType expQ[$];
    evType monGot;
    evType monExp;
    logic  monSeen;
    logic  prevTv;
    int    checks = 0;
    int    errors = 0;
    int    holdCycles;

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    initial begin
        #2000000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pushToken(input logic [3:0] pid, input logic [3:0] ep);
        expQ.push_back('{2'd1, {3'b000, pid, ep}});
    endtask

    task automatic pushSof(input logic [10:0] frame);
        expQ.push_back('{2'd2, frame});
    endtask

    task automatic pushErr();
        expQ.push_back('{2'd3, 11'h000});
    endtask

    task automatic sendByte(input logic [7:0] d, input logic last, input logic keep);
        int n = 0;
        @(negedge clk48);
        rxData = d; rxDataValid = 1'b1; rxIsLastByte = last; keepPacket = keep;
        while (!rxAcceptNewData && n < 100) begin
            @(negedge clk48);
            n++;
        end
        chk("accept_wait", 32'(rxAcceptNewData), 32'h1);
        @(posedge clk48);
        #1;
        rxDataValid = 1'b0; rxIsLastByte = 1'b0; keepPacket = 1'b0;
    endtask

    task automatic consumeToken();
        @(negedge clk48);
        tokenReady = 1'b1;
        @(posedge clk48);
        #1;
        tokenReady = 1'b0;
        chk("token_consumed", 32'(tokenValid), 32'h0);
    endtask

    // Scoreboard monitor: every reported event must match the head of the queue
    always @(negedge clk48) begin
        monSeen = 1'b0;
        if (tokenValid && !prevTv) begin
            monGot = '{2'd1, {3'b000, tokenPid, tokenEp}};
            monSeen = 1'b1;
        end else if (sofValid) begin
            monGot = '{2'd2, frameNumber};
            monSeen = 1'b1;
        end else if (pktError) begin
            monGot = '{2'd3, 11'h000};
            monSeen = 1'b1;
        end
        prevTv = tokenValid;
        if (monSeen) begin
            checks++;
            assert (expQ.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_event observed=%h expected=none", monGot);
            end
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checks++;
                assert (monGot === monExp) else begin
                    errors++;
                    $error("FAIL event_match observed=%h expected=%h", monGot, monExp);
                end
            end
        end
    end

    initial begin
        prevTv = 1'b0;
        rst_n = 1'b0; decodeEn = 1'b0; busReset = 1'b0; deviceAddr = 7'h05;
        rxData = 8'h00; rxDataValid = 1'b0; rxIsLastByte = 1'b0; keepPacket = 1'b0;
        tokenReady = 1'b0;
        repeat (3) @(posedge clk48);
        #1;
        chk("rst_tokenValid", 32'(tokenValid), 32'h0);
        chk("rst_accept", 32'(rxAcceptNewData), 32'h0);
        chk("rst_sofValid", 32'(sofValid), 32'h0);
        chk("rst_pktError", 32'(pktError), 32'h0);
        chk("rst_tokenPid", 32'(tokenPid), 32'h0);
        chk("rst_tokenEp", 32'(tokenEp), 32'h0);
        chk("rst_frame", 32'(frameNumber), 32'h0);
        rst_n = 1'b1;
        @(negedge clk48);
        decodeEn = 1'b1;

        // IN token addr 5 ep 1, held until consumed
        pushToken(4'b1001, 4'b0001);
        sendByte(8'h69, 1'b0, 1'b0);
        sendByte(8'h85, 1'b0, 1'b0);
        sendByte(8'h00, 1'b1, 1'b1);
        @(negedge clk48);
        chk("in_tokenValid", 32'(tokenValid), 32'h1);
        chk("in_tokenPid", 32'(tokenPid), 32'h9);
        chk("in_tokenEp", 32'(tokenEp), 32'h1);
        chk("in_accept_hold", 32'(rxAcceptNewData), 32'h0);
        repeat (10) @(negedge clk48);
        chk("in_held_valid", 32'(tokenValid), 32'h1);
        chk("in_held_ep", 32'(tokenEp), 32'h1);
        consumeToken();

        // SOF frame 0x7FF, then SOF with bad CRC leaves frame untouched
        pushSof(11'h7FF);
        sendByte(8'hA5, 1'b0, 1'b0);
        sendByte(8'hFF, 1'b0, 1'b0);
        sendByte(8'h07, 1'b1, 1'b1);
        @(negedge clk48);
        chk("sof_pulse", 32'(sofValid), 32'h1);
        chk("sof_frame", 32'(frameNumber), 32'h7FF);
        chk("sof_no_token", 32'(tokenValid), 32'h0);
        @(negedge clk48);
        chk("sof_pulse_end", 32'(sofValid), 32'h0);
        pushErr();
        sendByte(8'hA5, 1'b0, 1'b0);
        sendByte(8'h12, 1'b0, 1'b0);
        sendByte(8'h03, 1'b1, 1'b0);
        @(negedge clk48);
        chk("crc_err_pulse", 32'(pktError), 32'h1);
        chk("crc_err_frame_kept", 32'(frameNumber), 32'h7FF);
        @(negedge clk48);
        chk("crc_err_pulse_end", 32'(pktError), 32'h0);

        // PID check failure drains remaining bytes
        pushErr();
        sendByte(8'h61, 1'b0, 1'b0);
        sendByte(8'h11, 1'b0, 1'b0);
        sendByte(8'h22, 1'b1, 1'b1);
        @(negedge clk48);
        chk("pidfail_idle_accept", 32'(rxAcceptNewData), 32'h0);

        // OUT to another address is silent; short token is an error
        sendByte(8'hE1, 1'b0, 1'b0);
        sendByte(8'h06, 1'b0, 1'b0);
        sendByte(8'h00, 1'b1, 1'b1);
        @(negedge clk48);
        chk("mismatch_no_token", 32'(tokenValid), 32'h0);
        chk("mismatch_no_err", 32'(pktError), 32'h0);
        pushErr();
        sendByte(8'hE1, 1'b0, 1'b0);
        sendByte(8'h05, 1'b1, 1'b1);
        @(negedge clk48);
        chk("short_token_err", 32'(pktError), 32'h1);

        // Data packet drained silently, then SETUP ep 2
        sendByte(8'hC3, 1'b0, 1'b0);
        sendByte(8'h01, 1'b0, 1'b0);
        sendByte(8'h02, 1'b0, 1'b0);
        sendByte(8'h03, 1'b0, 1'b0);
        sendByte(8'h04, 1'b1, 1'b1);
        @(negedge clk48);
        chk("data_no_token", 32'(tokenValid), 32'h0);
        chk("data_no_err", 32'(pktError), 32'h0);
        pushToken(4'b1101, 4'b0010);
        sendByte(8'h2D, 1'b0, 1'b0);
        sendByte(8'h05, 1'b0, 1'b0);
        sendByte(8'h01, 1'b1, 1'b1);
        @(negedge clk48);
        chk("setup_pid", 32'(tokenPid), 32'hD);
        chk("setup_ep", 32'(tokenEp), 32'h2);
        consumeToken();

        // Hold timeout: token drops after exactly 255 cycles
        pushToken(4'b1001, 4'b0001);
        sendByte(8'h69, 1'b0, 1'b0);
        sendByte(8'h85, 1'b0, 1'b0);
        sendByte(8'h00, 1'b1, 1'b1);
        holdCycles = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk48);
            if (!tokenValid) break;
            holdCycles++;
        end
        chk("timeout_cycles", 32'(holdCycles), 32'd255);

        // Bus reset in HOLD wins over a simultaneous tokenReady
        pushToken(4'b1001, 4'b0001);
        sendByte(8'h69, 1'b0, 1'b0);
        sendByte(8'h85, 1'b0, 1'b0);
        sendByte(8'h00, 1'b1, 1'b1);
        @(negedge clk48);
        busReset = 1'b1; tokenReady = 1'b1;
        @(posedge clk48);
        #1;
        busReset = 1'b0; tokenReady = 1'b0;
        chk("busreset_tokenValid", 32'(tokenValid), 32'h0);
        chk("busreset_accept", 32'(rxAcceptNewData), 32'h0);
        chk("busreset_frame_kept", 32'(frameNumber), 32'h7FF);

        // Reset mid-ADDR clears outputs; leftover bytes parse as a new packet
        sendByte(8'h69, 1'b0, 1'b0);
        @(negedge clk48);
        rst_n = 1'b0;
        @(posedge clk48);
        #1;
        chk("midrst_tokenPid", 32'(tokenPid), 32'h0);
        chk("midrst_tokenEp", 32'(tokenEp), 32'h0);
        chk("midrst_frame", 32'(frameNumber), 32'h0);
        chk("midrst_accept", 32'(rxAcceptNewData), 32'h0);
        chk("midrst_tokenValid", 32'(tokenValid), 32'h0);
        rst_n = 1'b1;
        pushErr();
        sendByte(8'h85, 1'b0, 1'b0);
        sendByte(8'h00, 1'b1, 1'b1);
        pushToken(4'b1001, 4'b0001);
        sendByte(8'h69, 1'b0, 1'b0);
        sendByte(8'h85, 1'b0, 1'b0);
        sendByte(8'h00, 1'b1, 1'b1);
        @(negedge clk48);
        chk("post_rst_token", 32'(tokenValid), 32'h1);
        consumeToken();

        repeat (5) @(negedge clk48);
        chk("queue_empty", 32'(expQ.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_token_decoder.md
USB_TOKEN_DECODER -- requirements
Module: usb_token_decoder

Interface
REQ-001 Parameter: TOKEN_HOLD_TIMEOUT, default 255, meaning cycles HOLD waits for tokenReady before the token is dropped (0 = wait forever).
REQ-002 clk48  input  1  48 MHz clock; all logic synchronous to rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 decodeEn  input  1  PE is in PE_WAIT_FOR_TRANSACTION; decoder may consume rx bytes.
REQ-005 busReset  input  1  USB bus reset seen; aborts any decode.
REQ-006 deviceAddr  input  7  current device address.
REQ-007 rxData  input  8  received byte from SIE.
REQ-008 rxDataValid  input  1  rxData valid.
REQ-009 rxIsLastByte  input  1  current byte is last of packet.
REQ-010 keepPacket  input  1  CRC5 ok; meaningful only with last byte.
REQ-011 rxAcceptNewData  output  1  decoder accepts byte this cycle.
REQ-012 tokenValid  output  1  decoded IN/OUT/SETUP token available.
REQ-013 tokenPid  output  4  PID[3:0] of held token.
REQ-014 tokenEp  output  4  endpoint number of held token.
REQ-015 tokenReady  input  1  PE consumes token.
REQ-016 sofValid  output  1  one-cycle pulse: valid SOF decoded.
REQ-017 frameNumber  output  11  last valid SOF frame number.
REQ-018 pktError  output  1  one-cycle pulse: PID check, length or CRC failure.

Function
REQ-019 Byte transfer occurs only in a cycle with rxAcceptNewData=1 and rxDataValid=1.
REQ-020 rxAcceptNewData = 1 in states PID, ADDR, ENDP, DRAIN; 0 in IDLE, HOLD.
REQ-021 States: IDLE, PID, ADDR, ENDP, DRAIN, HOLD; IDLE -> PID the cycle after decodeEn=1.
REQ-022 PID: byte accepted; check rxData[7:4] == ~rxData[3:0]; fail -> pktError, DRAIN (IDLE if last).
REQ-023 PID: token PIDs OUT=0001, IN=1001, SETUP=1101, SOF=0101 -> ADDR; any other valid PID -> DRAIN, no error; if last byte -> IDLE.
REQ-024 ADDR: latch byte1; addr = byte1[6:0], ep[0] = byte1[7]; last byte here -> pktError, IDLE.
REQ-025 ENDP: byte2 must carry rxIsLastByte, else pktError, DRAIN; ep[3:1] = byte2[2:0]; frame = {byte2[2:0], byte1}.
REQ-026 ENDP last byte with keepPacket=0 -> pktError, IDLE, no outputs change.
REQ-027 Valid SOF -> frameNumber updated, sofValid pulses next cycle, IDLE; address not checked.
REQ-028 Valid IN/OUT/SETUP with addr == deviceAddr -> tokenPid/tokenEp loaded, tokenValid=1, HOLD; addr mismatch -> IDLE silently.
REQ-029 HOLD: tokenValid, tokenPid, tokenEp stable until tokenValid & tokenReady cycle, then tokenValid=0, IDLE.
REQ-030 HOLD timeout counter (8-bit) increments per cycle; reaching TOKEN_HOLD_TIMEOUT (non-zero) -> tokenValid=0, IDLE, no error pulse.
REQ-031 DRAIN: accept bytes until rxIsLastByte transfer, then IDLE; no outputs change.
REQ-032 decodeEn=0 in PID/ADDR/ENDP -> finish packet via DRAIN; decodeEn ignored in HOLD and DRAIN.
REQ-033 busReset=1 any state -> IDLE next cycle, tokenValid=0; frameNumber kept.
REQ-034 busReset and tokenReady same cycle -> busReset wins (token consumed, IDLE).

Reset
REQ-035 rst_n=0 at clock edge -> IDLE; tokenValid=0, sofValid=0, pktError=0, rxAcceptNewData=0, tokenPid=0, tokenEp=0, frameNumber=0, timeout counter=0.
REQ-036 Reset mid-packet discards the partial packet; remaining bytes with decodeEn=1 after reset are parsed as a new packet.

Verification
REQ-037 deviceAddr=0x05, bytes 0x69,0x85,0x00 (IN addr 5 ep 1), keepPacket=1 -> tokenValid=1, tokenPid=1001, tokenEp=0001, held until tokenReady.
REQ-038 Bytes 0xA5,0xFF,0x07, keepPacket=1 -> sofValid one cycle, frameNumber=0x7FF, tokenValid stays 0.
REQ-039 PID byte 0x61 (check mismatch) followed by 2 bytes -> one pktError pulse, bytes drained, IDLE.
REQ-040 OUT to addr 0x06 with deviceAddr=0x05 -> no tokenValid, no pktError; 2-byte token (last on byte1) -> pktError.
REQ-041 Data PID 0xC3 plus 4 bytes -> all drained, no outputs; then valid SETUP decoded normally.
REQ-042 Token held, tokenReady=0 for 255 cycles -> tokenValid drops; busReset in HOLD -> IDLE next cycle; rst_n=0 mid-ADDR -> all outputs 0.
